// File: rtl/uart_rx.sv
// UART receive path: oversampled start detect, 2-of-3 mid-bit vote,
// LSB-first deserialize, optional parity and stop check.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_t;

    state_t state, state_nx;

    logic [5:0]            edge_cnt;
    logic [5:0]            pre_q;
    logic [5:0]            half;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  s0;
    logic                  s1;
    logic                  bit_smp;
    logic                  par_bad;
    logic                  bit_end;
    logic                  last_bit;

    assign half     = {1'b0, pre_q[5:1]};
    assign bit_end  = (edge_cnt == pre_q - 6'd1);
    assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (!RX_IN) state_nx = START;
            START:   if (bit_end) state_nx = bit_smp ? IDLE : DATA;
            DATA:    if (bit_end && last_bit)
                         state_nx = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_nx = STOP;
            STOP:    if (bit_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_cnt   <= '0;
            pre_q      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            s0         <= 1'b0;
            s1         <= 1'b0;
            bit_smp    <= 1'b0;
            par_bad    <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (state == IDLE) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
                // detection cycle is edge 0, so the next cycle is edge 1
                if (!RX_IN) begin
                    edge_cnt  <= 6'd1;
                    pre_q     <= Prescale;
                    par_en_q  <= PAR_EN;
                    par_typ_q <= PAR_TYP;
                    par_bad   <= 1'b0;
                end
            end else begin
                edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
                if (edge_cnt == half - 6'd1) s0 <= RX_IN;
                if (edge_cnt == half)        s1 <= RX_IN;
                if (edge_cnt == half + 6'd1)
                    bit_smp <= (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
                if (bit_end) begin
                    case (state)
                        DATA: begin
                            shreg   <= {bit_smp, shreg[DATA_WIDTH-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        PARITY: par_bad <= bit_smp ^ (^shreg) ^ par_typ_q;
                        STOP: begin
                            if (!par_bad && bit_smp) begin
                                data_valid <= 1'b1;
                                P_DATA     <= shreg;
                            end else begin
                                par_err <= par_bad;
                                stp_err <= !bit_smp;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random frames, scored against an
// event model built from the frame format.
module tb_uart_rx;

    logic       CLK_tb = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    always #5 CLK_tb = ~CLK_tb;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK       (CLK_tb),
        .RST       (rst),
        .RX_IN     (rx_in),
        .Prescale  (prescale),
        .PAR_EN    (par_en),
        .PAR_TYP   (par_typ),
        .P_DATA    (p_data),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err)
    );

    typedef struct {
        int         cyc;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pd;
    } ev_t;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] model_pd = 8'h00;

    always @(posedge CLK_tb) cyc <= cyc + 1;

    always @(negedge CLK_tb) begin
        ev_t e;
        if (data_valid !== 1'b0 || par_err !== 1'b0 || stp_err !== 1'b0) begin
            e.cyc = cyc;
            e.dv  = data_valid;
            e.pe  = par_err;
            e.se  = stp_err;
            e.pd  = p_data;
            obs_q.push_back(e);
        end
    end

    task automatic step();
        @(posedge CLK_tb);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Cycle 0 of the frame is the cycle in which rx_in first goes low.
    task automatic send_frame(input int p, input logic [7:0] d,
                              input bit pen, input bit typ,
                              input bit bpar, input bit bstop,
                              input int flip_bit, input int flip_edge);
        logic [10:0] v;
        int          n;
        int          t0;
        bit          pcorr;
        bit          psent;
        bit          ok_par;
        bit          ok_stop;
        ev_t         e;
        pcorr = (($countones(d) % 2) == 1) ^ typ;
        psent = pcorr ^ bpar;
        v = '0;
        v[8:1] = d;
        if (pen) begin
            v[9]  = psent;
            v[10] = !bstop;
            n = 11;
        end else begin
            v[9] = !bstop;
            n = 10;
        end
        ok_par  = !pen || ((($countones(d) + int'(psent)) % 2) == int'(typ));
        ok_stop = !bstop;
        if (ok_par && ok_stop) model_pd = d;
        e.cyc = cyc + p * n;
        e.dv  = ok_par && ok_stop;
        e.pe  = !ok_par;
        e.se  = !ok_stop;
        e.pd  = model_pd;
        exp_q.push_back(e);
        prescale = 6'(p);
        par_en   = pen;
        par_typ  = typ;
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < p; k++) begin
                rx_in = (b == flip_bit && k == flip_edge) ? ~v[b] : v[b];
                step();
            end
        end
        rx_in = 1'b1;
    endtask

    task automatic check_events(input string tag);
        int n;
        repeat (3) step();
        chk({tag, ".n_events"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d].cyc", tag, i), obs_q[i].cyc, exp_q[i].cyc);
            chk($sformatf("%s[%0d].dv", tag, i), obs_q[i].dv, exp_q[i].dv);
            chk($sformatf("%s[%0d].pe", tag, i), obs_q[i].pe, exp_q[i].pe);
            chk($sformatf("%s[%0d].se", tag, i), obs_q[i].se, exp_q[i].se);
            chk($sformatf("%s[%0d].pd", tag, i), obs_q[i].pd, exp_q[i].pd);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int          ps[3];
        logic [10:0] v;
        int          p;
        int          fe;
        ps[0] = 8;
        ps[1] = 16;
        ps[2] = 32;

        rst      = 1'b1;
        rx_in    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        repeat (3) step();
        chk("rst.p_data", p_data, 8'h00);
        chk("rst.dv", data_valid, 1'b0);
        chk("rst.pe", par_err, 1'b0);
        chk("rst.se", stp_err, 1'b0);
        rst = 1'b0;
        idle(4);

        send_frame(8, 8'hA5, 0, 0, 0, 0, -1, -1);
        idle(5);
        check_events("p8_a5");

        send_frame(16, 8'h3C, 1, 0, 0, 0, -1, -1);
        idle(5);
        send_frame(16, 8'h3C, 1, 0, 1, 0, -1, -1);
        idle(5);
        check_events("p16_even");

        send_frame(8, 8'h55, 0, 0, 0, 1, -1, -1);
        idle(5);
        send_frame(8, 8'h12, 0, 0, 0, 0, -1, -1);
        idle(5);
        check_events("p8_stop");

        // glitch of 2 cycles, then a real start exactly at cycle P
        prescale = 6'd8;
        par_en   = 1'b0;
        rx_in    = 1'b0;
        repeat (2) step();
        rx_in = 1'b1;
        repeat (6) step();
        send_frame(8, 8'h5A, 0, 0, 0, 0, -1, -1);
        idle(5);
        send_frame(8, 8'hF0, 0, 0, 0, 0, 5, 4);
        idle(5);
        check_events("glitch_vote");

        send_frame(32, 8'h00, 1, 1, 0, 0, -1, -1);
        send_frame(32, 8'hFF, 1, 1, 0, 0, -1, -1);
        send_frame(32, 8'h81, 1, 1, 0, 0, -1, -1);
        idle(5);
        check_events("p32_b2b");

        prescale = 6'd8;
        par_en   = 1'b0;
        v = {1'b1, 8'h3A, 1'b0};
        for (int c = 0; c < 40; c++) begin
            rx_in = v[c / 8];
            step();
        end
        rst   = 1'b1;
        rx_in = 1'b1;
        step();
        step();
        chk("midrst.p_data", p_data, 8'h00);
        chk("midrst.dv", data_valid, 1'b0);
        chk("midrst.pe", par_err, 1'b0);
        chk("midrst.se", stp_err, 1'b0);
        rst      = 1'b0;
        model_pd = 8'h00;
        idle(100);
        send_frame(8, 8'h7E, 0, 0, 0, 0, -1, -1);
        idle(5);
        check_events("midrst");

        for (int i = 0; i < 16; i++) begin
            p = ps[$urandom_range(0, 2)];
            case ($urandom_range(0, 4))
                0:       fe = p / 2 - 1;
                1:       fe = p / 2;
                2:       fe = p / 2 + 1;
                3:       fe = 0;
                default: fe = p - 1;
            endcase
            send_frame(p, 8'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, 9), fe);
            idle($urandom_range(0, 2));
        end
        idle(5);
        check_events("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
